// File: rtl/fpga_spi_pkg.sv
// Shared state encoding and default parameters for the FPGA_SPI master, slave and benches.
// The master's SPI_LSB_FIRST_EN build option selects LSB-first shifting.
package fpga_spi_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_LEAD  = LEAD,
    S_SHIFT = SHIFT,
    S_GAP   = GAP
  } spi_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 5;
  localparam int DEF_SS_LEAD = 25;
  localparam int DEF_SS_GAP  = 2;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/fpga_spi_clkgen.sv
// SCLK generator: toggles SCLK every CLK_DIV enabled cycles and flags the edge
// that is about to happen with single-cycle rise/fall strobes.
module fpga_spi_clkgen
  import fpga_spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = cnt_w(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  // Strobes are valid in the cycle before the CLK edge that moves SCLK.
  assign wrap   = en_i && !clr_i && (div_q == DIV_LAST);
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        div_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/fpga_spi_master.sv
// SPI mode-0 master with START/BUSY/DONE handshake, one word per transfer.
// Define SPI_LSB_FIRST_EN for LSB-first shifting; default build is MSB-first.
module fpga_spi_master
  import fpga_spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SS_LEAD = DEF_SS_LEAD,
  parameter int SS_GAP  = DEF_SS_GAP
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS
);

  localparam int LW = cnt_w(SS_LEAD);
  localparam int GW = cnt_w(SS_GAP);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [LW-1:0] LEAD_LAST = LW'(SS_LEAD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SS_GAP - 1);
  localparam logic [BW-1:0] BITS      = BW'(DATA_W);

  spi_state_e        state_q;
  logic [LW-1:0]     lead_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic              ss_q, mosi_q, busy_q, done_q;
  logic              sclk_en, sclk_rise, sclk_fall;
  logic              first_bit, next_bit;
  logic [DATA_W-1:0] tx_shifted, rx_shifted;

  assign sclk_en = (state_q == S_SHIFT);

  fpga_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk    (CLK),
    .rst    (RST),
    .en_i   (sclk_en),
    .clr_i  (!sclk_en),
    .sclk_o (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

`ifdef SPI_LSB_FIRST_EN
  assign first_bit  = TX_DATA[0];
  assign next_bit   = tx_q[1];
  assign tx_shifted = tx_q >> 1;
  assign rx_shifted = {MISO, rx_q[DATA_W-1:1]};
`else
  assign first_bit  = TX_DATA[DATA_W-1];
  assign next_bit   = tx_q[DATA_W-2];
  assign tx_shifted = tx_q << 1;
  assign rx_shifted = {rx_q[DATA_W-2:0], MISO};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      lead_cnt_q <= '0;
      gap_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            tx_q       <= TX_DATA;
            mosi_q     <= first_bit;
            ss_q       <= 1'b0;
            busy_q     <= 1'b1;
            lead_cnt_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (lead_cnt_q == LEAD_LAST) state_q <= S_SHIFT;
          else lead_cnt_q <= lead_cnt_q + LW'(1);
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            rx_q      <= rx_shifted;
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end else if (sclk_fall) begin
            // The falling edge after the last rise closes the frame.
            if (bit_cnt_q == BITS) begin
              ss_q      <= 1'b1;
              mosi_q    <= 1'b0;
              rx_data_q <= rx_q;
              done_q    <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end else begin
              tx_q   <= tx_shifted;
              mosi_q <= next_bit;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RX_DATA = rx_data_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_fpga_spi_master.sv
// Self-checking bench for fpga_spi_master: default 8-bit instance plus a 16-bit CLK_DIV=1 instance.
module tb_fpga_spi_master;
  import fpga_spi_pkg::*;

  localparam int W     = 8;
  localparam int DIV   = 5;
  localparam int LEADC = 25;
  localparam int GAPC  = 2;
  localparam int W2    = 16;
  localparam int DIV2  = 1;
  localparam int T_RISE1 = LEADC + DIV;
  localparam int T_DONE  = LEADC + 2 * W * DIV;
  localparam int T_BUSY  = T_DONE + GAPC;
  localparam int T_DONE2 = LEADC + 2 * W2 * DIV2;
`ifdef SPI_LSB_FIRST_EN
  localparam logic [W-1:0] SEQ_9D = 8'hB9;
`else
  localparam logic [W-1:0] SEQ_9D = 8'h9D;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic [W-1:0]  tx = '0;
  logic [W2-1:0] tx2 = '0;
  logic busy, done, sclk, mosi, ss, miso = 1'b0;
  logic busy2, done2, sclk2, mosi2, ss2, miso2 = 1'b0;
  logic [W-1:0]  rx;
  logic [W2-1:0] rx2;

  always #10 clk = ~clk;

  fpga_spi_master #(.DATA_W(W), .CLK_DIV(DIV), .SS_LEAD(LEADC), .SS_GAP(GAPC)) dut (
    .CLK(clk), .RST(rst), .START(start), .TX_DATA(tx), .BUSY(busy), .DONE(done),
    .RX_DATA(rx), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS(ss));

  fpga_spi_master #(.DATA_W(W2), .CLK_DIV(DIV2), .SS_LEAD(LEADC), .SS_GAP(GAPC)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .TX_DATA(tx2), .BUSY(busy2), .DONE(done2),
    .RX_DATA(rx2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2), .SS(ss2));

  int n_checks = 0, n_fail = 0;
  int cyc = 0;

  // Wire position: k-th bit on the wire comes from this word bit.
  function automatic int wire_pos(input int k, input int width);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return width - 1 - k;
`endif
  endfunction

  // Expected MOSI bit stream, first wire bit in the MSB of the result.
  function automatic logic [W-1:0] wire_seq(input logic [W-1:0] w);
    logic [W-1:0] s;
    for (int k = 0; k < W; k++) s[W-1-k] = w[wire_pos(k, W)];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Observation state and slave models, updated on the falling CLK edge.
  logic [W-1:0] slave_word = '0;
  logic [W-1:0] mosi_seq = '0;
  int s_idx = 0, s2_idx = 0;
  int rise_cnt = 0, done_cnt = 0, done_cyc = -1, first_rise_cyc = -1;
  int ss_rise_cyc = -1, ss_low_cnt = 0, busy_fall_cyc = -1;
  int done2_cnt = 0, done2_cyc = -1;
  logic sclk_prev = 1'b0, ss_prev = 1'b1, busy_prev = 1'b0, sclk2_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (sclk && !sclk_prev) begin
      mosi_seq = {mosi_seq[W-2:0], mosi};
      if (rise_cnt == 0) first_rise_cyc = cyc;
      rise_cnt++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ss && !ss_prev) ss_rise_cyc = cyc;
    if (!ss) ss_low_cnt++;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    if (ss) s_idx = 0;
    else if (sclk && !sclk_prev) s_idx++;
    miso = (s_idx < W) ? slave_word[wire_pos(s_idx, W)] : 1'b0;
    if (ss2) s2_idx = 0;
    else if (sclk2 && !sclk2_prev) s2_idx++;
    miso2 = (s2_idx < W2) ? tx2[wire_pos(s2_idx, W2)] : 1'b0;
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    sclk_prev = sclk; ss_prev = ss; busy_prev = busy; sclk2_prev = sclk2;
  end

  task automatic clear_obs();
    mosi_seq = '0; rise_cnt = 0; done_cnt = 0; done_cyc = -1; first_rise_cyc = -1;
    ss_rise_cyc = -1; ss_low_cnt = 0; busy_fall_cyc = -1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); #1; n++; end
    check({tag, " idle"}, 32'(busy), 0);
  endtask

  // One full transfer; poke_at>0 re-raises START with 0xFF at that offset from E0.
  task automatic run_xfer(input string tag, input logic [W-1:0] t, input logic [W-1:0] sw,
                          input logic [W-1:0] exp_rx, input logic [W-1:0] exp_seq,
                          input int poke_at);
    int e0, n;
    wait_idle(tag);
    slave_word = sw; tx = t; start = 1'b1;
    clear_obs();
    @(negedge clk); #1;
    e0 = cyc; start = 1'b0;
    check({tag, " accept"}, {busy, ss, sclk, mosi}, {1'b1, 1'b0, 1'b0, exp_seq[W-1]});
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (poke_at > 0 && cyc - e0 == poke_at) begin start = 1'b1; tx = 8'hFF; end
      else start = 1'b0;
    end while (busy && n < 300);
    start = 1'b0;
    check({tag, " timeout"}, 32'(busy), 0);
    check({tag, " rx"}, 32'(rx), 32'(exp_rx));
    check({tag, " mosi"}, 32'(mosi_seq), 32'(exp_seq));
    check({tag, " rises"}, rise_cnt, W);
    check({tag, " dones"}, done_cnt, 1);
    check({tag, " done_t"}, done_cyc - e0, T_DONE);
    check({tag, " rise1_t"}, first_rise_cyc - e0, T_RISE1);
    check({tag, " ss_rise_t"}, ss_rise_cyc - e0, T_DONE);
    check({tag, " ss_low"}, ss_low_cnt, T_DONE);
    check({tag, " busy_fall_t"}, busy_fall_cyc - e0, T_BUSY);
    repeat (3) @(negedge clk);
    #1;
    check({tag, " no_requeue"}, {busy, ss}, 2'b01);
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] sw;
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int e0, n, h;
    logic [W-1:0] t, sw;
    vecs[0] = '{8'h9D, 8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'h80, 8'h01, 8'h01};
    vecs[4] = '{8'h3C, 8'hC3, 8'hC3};

    repeat (3) @(negedge clk);
    #1;
    check("reset outs", {sclk, ss, mosi, busy, done}, 5'b01000);
    check("reset rx", 32'(rx), 0);
    check("reset dut2", {sclk2, ss2, busy2, done2}, 4'b0100);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].sw, vecs[i].exp_rx,
               wire_seq(vecs[i].tx), 0);

    run_xfer("poke", 8'h9D, 8'hA5, 8'hA5, SEQ_9D, 40);

    // Asynchronous reset in the middle of bit 3.
    wait_idle("rst");
    slave_word = 8'hA5; tx = 8'h9D; start = 1'b1;
    clear_obs();
    @(negedge clk); #1;
    e0 = cyc; start = 1'b0;
    n = 0;
    while (cyc - e0 < 60 && n < 100) begin @(negedge clk); #1; n++; end
    rst = 1'b1;
    #1;
    check("rst async outs", {sclk, ss, mosi, busy, done}, 5'b01000);
    check("rst async rx", 32'(rx), 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (120) @(negedge clk);
    #1;
    check("rst no done", done_cnt, 0);
    check("rst idle", {busy, ss}, 2'b01);
    run_xfer("post_rst", 8'h3C, 8'h5A, 8'h5A, wire_seq(8'h3C), 0);

    // START held high: back-to-back transfers.
    wait_idle("b2b");
    slave_word = 8'hC3; tx = 8'h12; start = 1'b1;
    clear_obs();
    n = 0;
    while (done_cnt < 1 && n < 300) begin @(negedge clk); #1; n++; end
    check("b2b rx1", 32'(rx), 32'hC3);
    check("b2b mosi1", 32'(mosi_seq), 32'(wire_seq(8'h12)));
    tx = 8'h34; slave_word = 8'h69; mosi_seq = '0;
    h = 1; n = 0;
    while (n < 20) begin
      @(negedge clk); #1; n++;
      if (!ss) break;
      h++;
    end
    start = 1'b0;
    check("b2b ss gap", h, GAPC + 1);
    n = 0;
    while (done_cnt < 2 && n < 300) begin @(negedge clk); #1; n++; end
    check("b2b rx2", 32'(rx), 32'h69);
    check("b2b mosi2", 32'(mosi_seq), 32'(wire_seq(8'h34)));

    // Randomized transfers against the model.
    for (int i = 0; i < 8; i++) begin
      t = 8'($urandom);
      sw = 8'($urandom);
      run_xfer($sformatf("rand%0d", i), t, sw, sw, wire_seq(t), 0);
    end

    // 16-bit, CLK_DIV=1 instance with an echoing slave.
    tx2 = 16'hBEEF; start2 = 1'b1; done2_cnt = 0;
    @(negedge clk); #1;
    e0 = cyc; start2 = 1'b0;
    n = 0;
    while (busy2 && n < 200) begin @(negedge clk); #1; n++; end
    check("w16 timeout", 32'(busy2), 0);
    check("w16 rx", 32'(rx2), 32'hBEEF);
    check("w16 done_t", done2_cyc - e0, T_DONE2);
    check("w16 dones", done2_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
